// File: rtl/terminal_command_handler.sv
// Host byte-stream interpreter for the text terminal: printable chars, CR/LF/BS, VT52 ESC set,
// scroll offset and one-cell-per-cycle clears. Optional TERMINAL_AUTOWRAP_EN wraps at column 63.
module terminal_command_handler #(
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 4,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [7:0]                   data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic [COL_BITS+ROW_BITS-1:0] buffer_waddr,
    output logic [7:0]                   buffer_din,
    output logic                         buffer_wen,
    output logic [COL_BITS-1:0]          new_cursor_x,
    output logic [ROW_BITS-1:0]          new_cursor_y,
    output logic                         write_cursor_pos,
    output logic [ROW_BITS-1:0]          first_row,
    output logic [2:0]                   fsm_state
);

    typedef enum logic [2:0] {IDLE, ESC, ESCY_ROW, ESCY_COL, CLEAR} state_t;

    localparam logic [COL_BITS-1:0] MAX_X  = {COL_BITS{1'b1}};
    localparam logic [ROW_BITS-1:0] MAX_Y  = {ROW_BITS{1'b1}};
    localparam logic [7:0]          MAX_X8 = 8'(MAX_X);
    localparam logic [7:0]          MAX_Y8 = 8'(MAX_Y);

    state_t                         state, state_n;
    logic [COL_BITS-1:0]            cur_x, cur_x_n;
    logic [ROW_BITS-1:0]            cur_y, cur_y_n;
    logic [ROW_BITS-1:0]            fr, fr_n;
    logic [ROW_BITS-1:0]            clr_row, clr_row_n, end_row, end_row_n;
    logic [COL_BITS-1:0]            clr_col, clr_col_n;
    logic [7:0]                     esc_row, esc_row_n;
    logic [7:0]                     esc_col;
    logic                           chw, chw_n;
    logic [COL_BITS+ROW_BITS-1:0]   chw_addr, chw_addr_n;
    logic [7:0]                     chw_data, chw_data_n;
    logic                           wcp;
    logic                           accept, do_lf, clear_we;

    // Handshake: a byte transfers on any cycle where data_valid and data_ready are both high;
    // the source holds data_valid while data_ready is low.
    assign data_ready = (state != CLEAR);
    assign accept     = data_valid && data_ready;

    always_comb begin
        state_n    = state;
        cur_x_n    = cur_x;
        cur_y_n    = cur_y;
        fr_n       = fr;
        clr_row_n  = clr_row;
        clr_col_n  = clr_col;
        end_row_n  = end_row;
        esc_row_n  = esc_row;
        chw_n      = 1'b0;
        chw_addr_n = chw_addr;
        chw_data_n = chw_data;
        do_lf      = 1'b0;
        clear_we   = 1'b0;
        esc_col    = data_in - 8'h20;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (data_in >= 8'h20 && data_in <= 8'h7E) begin
                        chw_n      = 1'b1;
                        chw_addr_n = {cur_y + fr, cur_x};
                        chw_data_n = data_in;
                        if (cur_x != MAX_X) begin
                            cur_x_n = cur_x + 1'b1;
                        end else begin
`ifdef TERMINAL_AUTOWRAP_EN
                            cur_x_n = '0;
                            do_lf   = 1'b1;
`endif
                        end
                    end else if (data_in == 8'h0D) begin
                        cur_x_n = '0;
                    end else if (data_in == 8'h0A) begin
                        do_lf = 1'b1;
                    end else if (data_in == 8'h08) begin
                        if (cur_x != '0) cur_x_n = cur_x - 1'b1;
                    end else if (data_in == 8'h1B) begin
                        state_n = ESC;
                    end
                    // LF at the bottom row scrolls: the new logical row 15 is the old top row.
                    if (do_lf) begin
                        if (cur_y != MAX_Y) begin
                            cur_y_n = cur_y + 1'b1;
                        end else begin
                            fr_n      = fr + 1'b1;
                            state_n   = CLEAR;
                            clr_row_n = MAX_Y;
                            clr_col_n = '0;
                            end_row_n = MAX_Y;
                        end
                    end
                end
            end
            ESC: begin
                if (accept) begin
                    state_n = IDLE;
                    case (data_in)
                        8'h41: if (cur_y != '0) cur_y_n = cur_y - 1'b1;
                        8'h42: if (cur_y != MAX_Y) cur_y_n = cur_y + 1'b1;
                        8'h43: if (cur_x != MAX_X) cur_x_n = cur_x + 1'b1;
                        8'h44: if (cur_x != '0) cur_x_n = cur_x - 1'b1;
                        8'h48: begin
                            cur_x_n = '0;
                            cur_y_n = '0;
                        end
                        8'h4A, 8'h4B: begin
                            state_n   = CLEAR;
                            clr_row_n = cur_y;
                            clr_col_n = cur_x;
                            end_row_n = (data_in == 8'h4A) ? MAX_Y : cur_y;
                        end
                        8'h59:   state_n = ESCY_ROW;
                        default: state_n = IDLE;
                    endcase
                end
            end
            ESCY_ROW: begin
                if (accept) begin
                    esc_row_n = data_in - 8'h20;
                    state_n   = ESCY_COL;
                end
            end
            ESCY_COL: begin
                if (accept) begin
                    if (esc_row <= MAX_Y8) cur_y_n = esc_row[ROW_BITS-1:0];
                    if (esc_col <= MAX_X8) cur_x_n = esc_col[COL_BITS-1:0];
                    state_n = IDLE;
                end
            end
            CLEAR: begin
                // A wrapped char write still pending takes the port first; the clear waits one cycle.
                if (!chw) begin
                    clear_we = 1'b1;
                    if (clr_col == MAX_X && clr_row == end_row) begin
                        state_n = IDLE;
                    end else if (clr_col == MAX_X) begin
                        clr_col_n = '0;
                        clr_row_n = clr_row + 1'b1;
                    end else begin
                        clr_col_n = clr_col + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            cur_x    <= '0;
            cur_y    <= '0;
            fr       <= '0;
            clr_row  <= '0;
            clr_col  <= '0;
            end_row  <= '0;
            esc_row  <= '0;
            chw      <= 1'b0;
            chw_addr <= '0;
            chw_data <= '0;
            wcp      <= 1'b0;
        end else begin
            state    <= state_n;
            cur_x    <= cur_x_n;
            cur_y    <= cur_y_n;
            fr       <= fr_n;
            clr_row  <= clr_row_n;
            clr_col  <= clr_col_n;
            end_row  <= end_row_n;
            esc_row  <= esc_row_n;
            chw      <= chw_n;
            chw_addr <= chw_addr_n;
            chw_data <= chw_data_n;
            wcp      <= (cur_x_n != cur_x) || (cur_y_n != cur_y);
        end
    end

    assign buffer_wen       = chw || clear_we;
    assign buffer_waddr     = chw ? chw_addr : (clear_we ? {clr_row + fr, clr_col} : '0);
    assign buffer_din       = chw ? chw_data : (clear_we ? BLANK_CHAR : 8'h00);
    assign new_cursor_x     = cur_x;
    assign new_cursor_y     = cur_y;
    assign write_cursor_pos = wcp;
    assign first_row        = fr;
    assign fsm_state        = state;

endmodule
